// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared constants and types for the APB3 slave and its register file.
//   ADDR_W    : APB address width (bit 8 is the master's slave decode)
//   DATA_W    : APB data width
//   MEM_DEPTH : number of register-file entries
//   IDX_W     : register-file index width
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int ADDR_W    = 9;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 64;
  localparam int IDX_W     = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_slave_state_t;

endpackage

// File: rtl/apb_slave_regfile.sv
// -----------------------------------------------------------------------------
// apb_slave_regfile
// 64x8 register array: one synchronous write port, one combinational read
// port, every entry cleared asynchronously by the active-low reset.
// Ports:
//   clk    : clock (rising edge)
//   rst_n  : asynchronous active-low reset, clears all entries to 0
//   we     : write enable
//   waddr  : write index
//   wdata  : write data
//   raddr  : read index
//   rdata  : combinational read data
// -----------------------------------------------------------------------------
module apb_slave_regfile
  import apb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave.sv
// -----------------------------------------------------------------------------
// apb_slave
// APB3 peripheral slave backed by a 64x8 register file, with a fixed number
// of wait states inserted before PREADY.
//
// Optional feature macro: APB_SLAVE_PSLVERR_EN
//   defined   : PSLVERR port exists; PADDR[7:6] != 0 gives an error response
//               (write suppressed, read returns 0), normal wait-state timing.
//   undefined : no PSLVERR port; PADDR[7:6] ignored (addresses alias mod 64).
//
// Parameters:
//   WAIT_STATES : extra access cycles before PREADY (0..15)
// Ports:
//   PCLK     : clock (rising edge)
//   PRESETn  : asynchronous active-low reset
//   PSEL     : slave select
//   PENABLE  : access phase marker
//   PWRITE   : 1 = write, 0 = read
//   PADDR    : address; bit 8 is the master's decode and is ignored
//   PWDATA   : write data
//   PRDATA   : registered read data, holds between reads
//   PREADY   : registered one-cycle transfer completion
//   PSLVERR  : registered error response (only with APB_SLAVE_PSLVERR_EN)
// -----------------------------------------------------------------------------
module apb_slave
  import apb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY
`ifdef APB_SLAVE_PSLVERR_EN
  ,
  output logic              PSLVERR
`endif
);

  localparam logic [3:0] WS = WAIT_STATES[3:0];

  apb_slave_state_t state, state_nxt;

  logic [3:0]        cnt;
  logic [IDX_W+1:0]  addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;

  logic              setup;
  logic              enter_ready;
  logic              rd_load;
  logic              mem_we;
  logic              addr_err;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] mem_rdata;

  assign setup = PSEL && !PENABLE;

  // State register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Dropping PSEL mid-transfer abandons it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (setup) begin
          state_nxt = (WS == 4'd0) ? READY : WAIT;
        end
      end
      WAIT: begin
        if (!PSEL) begin
          state_nxt = IDLE;
        end else if (cnt <= 4'd1) begin
          state_nxt = READY;
        end
      end
      READY: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output/control decode. With zero wait states READY is entered straight
  // from the setup edge, before the request has been latched, so the read
  // index and direction come from the bus in IDLE and from the latch later.
  always_comb begin
    enter_ready = (state_nxt == READY);
    rd_idx      = (state == IDLE) ? PADDR[IDX_W-1:0] : addr_q[IDX_W-1:0];
    rd_load     = enter_ready && !((state == IDLE) ? PWRITE : write_q);
`ifdef APB_SLAVE_PSLVERR_EN
    addr_err    = (state == IDLE) ? (PADDR[IDX_W+1:IDX_W] != 2'b00)
                                  : (addr_q[IDX_W+1:IDX_W] != 2'b00);
    mem_we      = (state == READY) && PSEL && write_q
                  && (addr_q[IDX_W+1:IDX_W] == 2'b00);
`else
    addr_err    = 1'b0;
    mem_we      = (state == READY) && PSEL && write_q;
`endif
  end

  // Wait-state counter: loaded on setup, counts down while waiting
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt <= 4'd0;
    end else if (state == IDLE && setup) begin
      cnt <= WS;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Request latch (data only, no reset needed)
  always_ff @(posedge PCLK) begin
    if (state == IDLE && setup) begin
      addr_q  <= PADDR[IDX_W+1:0];
      write_q <= PWRITE;
      wdata_q <= PWDATA;
    end
  end

  // Registered bus outputs
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PREADY <= 1'b0;
      PRDATA <= '0;
    end else begin
      PREADY <= enter_ready;
      if (rd_load) begin
        PRDATA <= addr_err ? '0 : mem_rdata;
      end
    end
  end

`ifdef APB_SLAVE_PSLVERR_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSLVERR <= 1'b0;
    end else begin
      PSLVERR <= enter_ready && addr_err;
    end
  end

  logic unused_bits;
  assign unused_bits = PADDR[ADDR_W-1];
`else
  // Decode bit and upper index bits are deliberately ignored in this build
  logic unused_bits;
  assign unused_bits = ^{PADDR[ADDR_W-1:IDX_W], addr_q[IDX_W+1:IDX_W], addr_err};
`endif

  apb_slave_regfile u_regfile (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (mem_we),
    .waddr (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_apb_slave.sv
module tb_apb_slave;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic [2:0] psel;
  logic       PENABLE;
  logic       PWRITE;
  logic [8:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] prdata [3];
  logic [2:0] pready;
  logic [2:0] pslverr;

  int errors = 0;
  int checks = 0;
  int dbl    = 0;
  logic [2:0] pready_prev = 3'b000;
  logic       last_err;

  always #5 PCLK = ~PCLK;

  apb_slave #(.WAIT_STATES(0)) u_ws0 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[0]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(prdata[0]), .PREADY(pready[0])
`ifdef APB_SLAVE_PSLVERR_EN
    , .PSLVERR(pslverr[0])
`endif
  );

  apb_slave #(.WAIT_STATES(2)) u_ws2 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[1]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(prdata[1]), .PREADY(pready[1])
`ifdef APB_SLAVE_PSLVERR_EN
    , .PSLVERR(pslverr[1])
`endif
  );

  apb_slave #(.WAIT_STATES(3)) u_ws3 (
    .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(psel[2]), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(prdata[2]), .PREADY(pready[2])
`ifdef APB_SLAVE_PSLVERR_EN
    , .PSLVERR(pslverr[2])
`endif
  );

`ifndef APB_SLAVE_PSLVERR_EN
  assign pslverr = 3'b000;
`endif

  // PREADY must never be high on two consecutive cycles on any slave
  always @(negedge PCLK) begin
    if ((pready & pready_prev) != 3'b000) dbl++;
    pready_prev <= pready;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transfer on slave d; called #1 after a rising edge, returns #1 after
  // the completing edge with the bus idle. n = access cycle in which PREADY
  // was seen (capped at 20 on timeout).
  task automatic xfer(input int d, input bit wr, input logic [8:0] a,
                      input logic [7:0] wd, output logic [7:0] rd, output int n);
    psel[d] = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = wd;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    n = 1;
    while (!pready[d] && n < 20) begin
      @(posedge PCLK); #1;
      n++;
    end
    rd = prdata[d];
    last_err = pslverr[d];
    @(posedge PCLK); #1;
    chk("pready_drops_after_completion", {31'd0, pready[d]}, 32'd0);
    psel[d] = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    int n;
    int hi;

    PRESETn = 1'b0; psel = 3'b000; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0;
    repeat (3) @(posedge PCLK);
    #1;
    // Reset state
    chk("reset_pready", {29'd0, pready}, 32'd0);
    chk("reset_prdata0", {24'd0, prdata[0]}, 32'h00);
    chk("reset_prdata1", {24'd0, prdata[1]}, 32'h00);
    chk("reset_prdata2", {24'd0, prdata[2]}, 32'h00);
    chk("reset_pslverr", {29'd0, pslverr}, 32'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Basic write then read, zero wait states
    xfer(0, 1'b1, 9'h002, 8'h33, rd, n);
    chk("ws0_write_latency", n, 1);
    xfer(0, 1'b0, 9'h002, 8'h00, rd, n);
    chk("ws0_read_latency", n, 1);
    chk("ws0_read_data", {24'd0, rd}, 32'h33);

    // Writes leave PRDATA alone
    xfer(0, 1'b1, 9'h003, 8'h44, rd, n);
    chk("prdata_hold_after_write", {24'd0, prdata[0]}, 32'h33);

    // Wait states: PREADY in the 3rd access cycle
    xfer(1, 1'b1, 9'h102, 8'h0F, rd, n);
    chk("ws2_write_latency", n, 3);
    xfer(1, 1'b0, 9'h102, 8'h00, rd, n);
    chk("ws2_read_latency", n, 3);
    chk("ws2_read_data", {24'd0, rd}, 32'h0F);

    // Back-to-back transfers with no idle cycle between them
    xfer(0, 1'b1, 9'h005, 8'hA5, rd, n);
    xfer(0, 1'b1, 9'h006, 8'h5A, rd, n);
    chk("b2b_write2_latency", n, 1);
    xfer(0, 1'b0, 9'h005, 8'h00, rd, n);
    chk("b2b_read5", {24'd0, rd}, 32'hA5);
    xfer(0, 1'b0, 9'h006, 8'h00, rd, n);
    chk("b2b_read6", {24'd0, rd}, 32'h5A);
    chk("b2b_read6_latency", n, 1);

    // Error / alias address
    xfer(0, 1'b1, 9'h0C2, 8'h77, rd, n);
    chk("alias_write_latency", n, 1);
`ifdef APB_SLAVE_PSLVERR_EN
    chk("err_pslverr_with_pready", {31'd0, last_err}, 32'd1);
    chk("err_pslverr_clears", {29'd0, pslverr}, 32'd0);
    xfer(0, 1'b0, 9'h002, 8'h00, rd, n);
    chk("err_addr2_unchanged", {24'd0, rd}, 32'h33);
    xfer(0, 1'b0, 9'h0C2, 8'h00, rd, n);
    chk("err_read_zero", {24'd0, rd}, 32'h00);
    chk("err_read_pslverr", {31'd0, last_err}, 32'd1);
`else
    chk("alias_no_err", {31'd0, last_err}, 32'd0);
    xfer(0, 1'b0, 9'h002, 8'h00, rd, n);
    chk("alias_read_addr2", {24'd0, rd}, 32'h77);
`endif

    // Dropped PSEL while waiting (3 wait states)
    xfer(2, 1'b1, 9'h009, 8'h11, rd, n);
    chk("ws3_write_latency", n, 4);
    psel[2] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 9'h009; PWDATA = 8'hEE;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    chk("drop_access1_pready", {31'd0, pready[2]}, 32'd0);
    @(posedge PCLK); #1;
    chk("drop_access2_pready", {31'd0, pready[2]}, 32'd0);
    psel[2] = 1'b0; PENABLE = 1'b0;
    hi = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge PCLK); #1;
      if (pready[2]) hi++;
    end
    chk("drop_no_pready", hi, 0);
    xfer(2, 1'b0, 9'h009, 8'h00, rd, n);
    chk("drop_no_write", {24'd0, rd}, 32'h11);
    chk("drop_then_latency", n, 4);

    // Reset pulse during the access phase of a write of FF to addr 7
    psel[0] = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 9'h007; PWDATA = 8'hFF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    chk("rst_mid_pready_before", {31'd0, pready[0]}, 32'd1);
    #2 PRESETn = 1'b0;
    #1;
    chk("rst_mid_pready_now", {31'd0, pready[0]}, 32'd0);
    chk("rst_mid_prdata", {24'd0, prdata[0]}, 32'h00);
    #1 PRESETn = 1'b1;
    @(posedge PCLK); #1;
    chk("rst_mid_no_pready_after", {29'd0, pready}, 32'd0);
    psel[0] = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    xfer(0, 1'b0, 9'h007, 8'h00, rd, n);
    chk("rst_mid_addr7", {24'd0, rd}, 32'h00);
    xfer(0, 1'b0, 9'h005, 8'h00, rd, n);
    chk("rst_cleared_addr5", {24'd0, rd}, 32'h00);
    xfer(1, 1'b0, 9'h102, 8'h00, rd, n);
    chk("rst_cleared_ws2_addr2", {24'd0, rd}, 32'h00);

    @(posedge PCLK); #1;
    chk("pready_never_consecutive", dbl, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_slave.md
# apb_slave

APB3-style peripheral slave with a 64×8 register file and programmable wait states. It sits directly downstream of `apb_master` and is instantiated once per select line, with `PSEL` tied to `PSEL1` or `PSEL2`. It replaces the behavioural slave models used in simulation with synthesizable RTL that completes master-initiated read and write transfers.

## Interface
- `WAIT_STATES`, default 0: extra access cycles inserted before `PREADY` asserts (0–15).
- `PCLK` input, 1 bit: clock; all logic is rising-edge.
- `PRESETn` input, 1 bit: asynchronous active-low reset.
- `PSEL` input, 1 bit: slave select from the master.
- `PENABLE` input, 1 bit: marks the access phase.
- `PWRITE` input, 1 bit: 1 = write, 0 = read.
- `PADDR` input, 9 bits: address; bit 8 is the master's slave decode and is ignored here.
- `PWDATA` input, 8 bits: write data.
- `PRDATA` output, 8 bits: read data, registered.
- `PREADY` output, 1 bit: transfer completion, registered.
- `PSLVERR` output, 1 bit: error response. Present only with `APB_SLAVE_PSLVERR_EN`.

## Operation
- FSM states: `IDLE`, `WAIT`, `READY`.
- **IDLE:**
  - Setup is sampled as `PSEL=1` and `PENABLE=0`.
  - On setup, latch `PADDR[7:0]`, `PWRITE` and `PWDATA`.
  - Load the wait counter with `WAIT_STATES`.
  - Next state is `READY` if `WAIT_STATES==0`, else `WAIT`.
- **WAIT:** decrement the counter each cycle; move to `READY` on the edge where the counter reaches 1.
- **Entering READY:**
  - Read: `PRDATA` is loaded from `mem[addr[5:0]]`.
  - `PREADY=1` for exactly one cycle.
- **Leaving READY (the completing edge):**
  - Write: `mem[addr[5:0]]` is written with `PWDATA`.
  - Next state is `IDLE`.
- **Protocol violation:** if `PSEL` drops in `WAIT` or `READY`, return to `IDLE` with no memory write and `PREADY` deasserted.
- **Back-to-back transfers:** the master re-issues a setup cycle; `IDLE` detects it on the cycle after `READY`.
- `PRDATA` holds its last read value between reads. Writes never change `PRDATA`.
- Address width rule: the memory index is `PADDR[5:0]`. `PADDR[7:6]` are checked only when `APB_SLAVE_PSLVERR_EN` is defined.

## Timing
- **Reset values:** `PREADY=0`, `PRDATA=8'h00`, `PSLVERR=0`, FSM=`IDLE`, counter=0, every memory entry = `8'h00`.
- Reset is asynchronous: asserting it mid-transfer forces all of the above immediately. That transfer never completes and no write occurs.
- **Latency:** `PREADY` is high in access cycle number `WAIT_STATES+1`, counted from the first cycle with `PENABLE=1`.
- Zero-wait operation gives the standard 2-cycle APB transfer.
- Write data is visible to a read issued in the next transfer.
- `PREADY` is never high outside `READY`. It is never high for two consecutive cycles.

## Configuration
- **`APB_SLAVE_PSLVERR_EN` defined:**
  - `PSLVERR` port exists.
  - A transfer with `PADDR[7:6]!=0` still completes with normal wait-state timing.
  - `PSLVERR=1` in the `READY` cycle only.
  - The write is suppressed.
  - A read returns `PRDATA=8'h00`.
- **`APB_SLAVE_PSLVERR_EN` undefined:**
  - No `PSLVERR` port.
  - `PADDR[7:6]` are ignored, so addresses alias modulo 64.

## Structure
- Package `apb_pkg` holds:
  - `ADDR_W=9`, `DATA_W=8`, `MEM_DEPTH=64`, `IDX_W=6`
  - `typedef enum logic [1:0] {IDLE, WAIT, READY} apb_slave_state_t`
- Sub-module `apb_slave_regfile` holds the 64×8 array:
  - One synchronous write port.
  - One combinational read port.
  - Async clear on `PRESETn`.
- The FSM, wait counter and output registers stay in `apb_slave`.

## Test plan
- **Basic write then read:** `WAIT_STATES=0`; write `8'h33` to `PADDR=9'h002`, then read `9'h002`. `PREADY` is high in the first access cycle of each transfer and `PRDATA=8'h33`.
- **Wait states:** `WAIT_STATES=2`; write `8'h0F` to `9'h102`. `PREADY` is low for 2 access cycles and high on the 3rd. A read of `9'h102` then returns `8'h0F`.
- **Back-to-back:** writes of `8'hA5`→addr 5 and `8'h5A`→addr 6 in consecutive transfers, then reads of both. Expect `8'hA5`, then `8'h5A`; `PREADY` never high two cycles in a row.
- **Reset mid-transfer:** pulse `PRESETn` low during the access phase of a write of `8'hFF` to addr 7. `PREADY=0` immediately; a subsequent read of addr 7 returns `8'h00`.
- **Dropped `PSEL`:** deassert `PSEL` in `WAIT` (`WAIT_STATES=3`). FSM returns to `IDLE`, no write, no `PREADY`.
- **Error/alias address:** write `8'h77` to `PADDR=9'h0C2`.
  - With `APB_SLAVE_PSLVERR_EN`: `PSLVERR=1` with `PREADY`, and addr 2 is unchanged.
  - Without it: a read of `9'h002` returns `8'h77`.
